vector_serializer: RTL

//   Transmit side of the serial vector link: accepts parallel WIDTH-bit vectors over a valid/ready handshake.

---
 rtl/vector_serializer_pkg.sv | 15 +
 rtl/vector_shift_reg.sv | 46 ++++
 rtl/vector_serializer.sv | 119 +++++++++++
 3 files changed

// File: rtl/vector_serializer_pkg.sv
// Shared definitions for the serial vector link: default vector width and control FSM codes.
// Both ends of the link import this so they agree on width.
package vector_serializer_pkg;

  localparam int VECTOR_WIDTH = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Bit-counter width; a 1-bit minimum keeps degenerate widths legal.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/vector_shift_reg.sv
// Parallel-load shift register with a serial tap at the end selected by LSB_FIRST.
// Load has priority over shift; both update on the rising edge.
module vector_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_dat_i,
  input  logic             shift_i,
  output logic             bit_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] sr_shifted;

  always_comb begin
    if (LSB_FIRST) begin
      sr_shifted = {1'b0, sr_q[WIDTH-1:1]};
    end else begin
      sr_shifted = {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = load_dat_i;
    end else if (shift_i) begin
      sr_d = sr_shifted;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign bit_o = LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];

endmodule

// File: rtl/vector_serializer.sv
// Serializes WIDTH-bit vectors one bit per bit handshake, with a one-entry holding
// register so the next vector can be accepted while the current one shifts out.
module vector_serializer
  import vector_serializer_pkg::*;
#(
  parameter int WIDTH     = VECTOR_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] vector_i,
  input  logic             vector_valid_i,
  output logic             ready_o,
  output logic             output_bit_o,
  output logic             bit_valid_o,
  input  logic             bit_ready_i,
  output logic             busy_o,
  output logic             done_o
);

  localparam int              CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hr_q, hr_d;
  logic             hr_full_q, hr_full_d;
  logic             done_q, done_d;

  logic             take;
  logic             last;
  logic             accept;
  logic             sr_load;
  logic [WIDTH-1:0] sr_load_dat;
  logic             sr_shift;

  assign bit_valid_o = (state_q == ST_SHIFT);
  assign busy_o      = (state_q == ST_SHIFT);
  assign done_o      = done_q;
  assign ready_o     = !reset_i && !hr_full_q;
  assign accept      = vector_valid_i && ready_o;
  assign take        = bit_valid_o && bit_ready_i;
  assign last        = take && (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hr_d        = hr_q;
    hr_full_d   = hr_full_q;
    done_d      = 1'b0;
    sr_load     = 1'b0;
    sr_load_dat = vector_i;
    sr_shift    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sr_load = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      default: begin
        if (last) begin
          done_d = 1'b1;
          // Refill straight from HR or the input so back-to-back vectors have no bubble.
          if (hr_full_q) begin
            sr_load     = 1'b1;
            sr_load_dat = hr_q;
            hr_full_d   = 1'b0;
            cnt_d       = '0;
          end else if (accept) begin
            sr_load = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (take) begin
            sr_shift = 1'b1;
            cnt_d    = cnt_q + CW'(1);
          end
          if (accept) begin
            hr_d      = vector_i;
            hr_full_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hr_q      <= '0;
      hr_full_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hr_q      <= hr_d;
      hr_full_q <= hr_full_d;
      done_q    <= done_d;
    end
  end

  vector_shift_reg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift_reg (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (sr_load),
    .load_dat_i (sr_load_dat),
    .shift_i    (sr_shift),
    .bit_o      (output_bit_o)
  );

endmodule
